// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage branch / pipeline-control bundle between the branch logic and the redirect controller.
// The master drives the branch result and stall; the slave (controller) drives redirect and flushes.
interface branch_redirect_ctrl_if #(
    parameter int PC_W = 16
) ();
    logic            ex_branch;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic            pipe_stall;
    logic            pc_redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_if;
    logic            flush_id;
    logic            busy;

    modport master (
        output ex_branch, ex_taken, ex_target, pipe_stall,
        input  pc_redirect, redirect_pc, flush_if, flush_id, busy
    );

    modport slave (
        input  ex_branch, ex_taken, ex_target, pipe_stall,
        output pc_redirect, redirect_pc, flush_if, flush_id, busy
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Taken-branch sequencer: one-cycle PC redirect, then FLUSH_CYCLES advancing cycles of IF/ID + ID/EX squash.
// Latency 1 cycle from resolution to redirect; stalls defer the redirect (HOLD) and stretch the flush.
// Optional BRANCH_PERF_CNT_EN adds branch / taken-branch counters with a synchronous clear.
module branch_redirect_ctrl #(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_redirect_ctrl_if.slave bus
`ifdef BRANCH_PERF_CNT_EN
    ,
    input  logic                  perf_clr,
    output logic [15:0]           br_count,
    output logic [15:0]           taken_count
`endif
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("branch_redirect_ctrl: FLUSH_CYCLES must be in 1..7");
    end

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic [PC_W-1:0] tgt_q;
    logic            pc_redirect_q;
    logic            flush_q;
    logic            busy_q;
    logic            trigger;

    assign trigger = (state_q == IDLE) && bus.ex_branch && bus.ex_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            tgt_q         <= '0;
            pc_redirect_q <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            pc_redirect_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (trigger) begin
                        tgt_q  <= bus.ex_target;
                        busy_q <= 1'b1;
                        if (bus.pipe_stall) begin
                            state_q <= HOLD;
                        end else begin
                            state_q       <= FLUSH;
                            pc_redirect_q <= 1'b1;
                            flush_q       <= 1'b1;
                            cnt_q         <= FLUSH_LOAD;
                        end
                    end
                end
                HOLD: begin
                    // Target already latched; EX contents are frozen garbage until the stall lifts.
                    if (!bus.pipe_stall) begin
                        state_q       <= FLUSH;
                        pc_redirect_q <= 1'b1;
                        flush_q       <= 1'b1;
                        cnt_q         <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (!bus.pipe_stall) begin
                        if (cnt_q == 3'd1) begin
                            state_q <= IDLE;
                            flush_q <= 1'b0;
                            busy_q  <= 1'b0;
                            cnt_q   <= 3'd0;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.pc_redirect = pc_redirect_q;
    assign bus.redirect_pc = tgt_q;
    assign bus.flush_if    = flush_q;
    assign bus.flush_id    = flush_q;
    assign bus.busy        = busy_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [15:0] br_count_q;
    logic [15:0] taken_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q    <= 16'd0;
            taken_count_q <= 16'd0;
        end else if (perf_clr) begin
            br_count_q    <= 16'd0;
            taken_count_q <= 16'd0;
        end else begin
            if ((state_q == IDLE) && bus.ex_branch && !bus.pipe_stall) begin
                br_count_q <= br_count_q + 16'd1;
            end
            if (trigger) begin
                taken_count_q <= taken_count_q + 16'd1;
            end
        end
    end

    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Table-driven bench for branch_redirect_ctrl (FLUSH_CYCLES=2) with a scoreboard queue of expected outputs,
// plus hand-written reset-during-FLUSH/HOLD sequences and, when built with BRANCH_PERF_CNT_EN, counter checks.
module tb_branch_redirect_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    branch_redirect_ctrl_if #(.PC_W(16)) bus ();

`ifdef BRANCH_PERF_CNT_EN
    logic        perf_clr;
    logic [15:0] br_count;
    logic [15:0] taken_count;
`endif

    branch_redirect_ctrl #(.PC_W(16), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .perf_clr    (perf_clr),
        .br_count    (br_count),
        .taken_count (taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic        tk;
        logic [15:0] tgt;
        logic        rd;
        logic [15:0] rpc;
        logic        fl;
        logic        bz;
    } vec_t;

    typedef struct {
        int          row;
        logic        rd;
        logic [15:0] rpc;
        logic        fl;
        logic        bz;
    } exp_t;

    localparam int NV = 21;
    vec_t vecs [0:NV-1];
    exp_t sb [$];

    function automatic vec_t mk(logic st, logic br, logic tk, logic [15:0] tgt,
                                logic rd, logic [15:0] rpc, logic fl, logic bz);
        vec_t v;
        v.st = st; v.br = br; v.tk = tk; v.tgt = tgt;
        v.rd = rd; v.rpc = rpc; v.fl = fl; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rd, input logic [15:0] rpc,
                            input logic fl, input logic bz);
        chk({tag, ".pc_redirect"}, 32'(bus.pc_redirect), 32'(rd));
        chk({tag, ".redirect_pc"}, 32'(bus.redirect_pc), 32'(rpc));
        chk({tag, ".flush_if"},    32'(bus.flush_if),    32'(fl));
        chk({tag, ".flush_id"},    32'(bus.flush_id),    32'(fl));
        chk({tag, ".busy"},        32'(bus.busy),        32'(bz));
    endtask

    task automatic drive(input logic st, input logic br, input logic tk, input logic [15:0] tgt);
        bus.pipe_stall = st;
        bus.ex_branch  = br;
        bus.ex_taken   = tk;
        bus.ex_target  = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
`ifdef BRANCH_PERF_CNT_EN
        perf_clr = 1'b0;
`endif

        // Columns: stall, branch, taken, target | redirect, redirect_pc, flush, busy (after the edge)
        vecs[0]  = mk(0, 1, 1, 16'h0040, 1, 16'h0040, 1, 1);
        vecs[1]  = mk(0, 0, 0, 16'h0000, 0, 16'h0040, 1, 1);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 0, 16'h0040, 0, 0);
        vecs[3]  = mk(0, 1, 0, 16'h1234, 0, 16'h0040, 0, 0);
        vecs[4]  = mk(0, 1, 0, 16'h1234, 0, 16'h0040, 0, 0);
        vecs[5]  = mk(0, 0, 0, 16'h1234, 0, 16'h0040, 0, 0);
        vecs[6]  = mk(1, 1, 1, 16'h00A0, 0, 16'h00A0, 0, 1);
        vecs[7]  = mk(1, 1, 1, 16'hFFFF, 0, 16'h00A0, 0, 1);
        vecs[8]  = mk(1, 0, 0, 16'hFFFF, 0, 16'h00A0, 0, 1);
        vecs[9]  = mk(0, 1, 1, 16'hFFFF, 1, 16'h00A0, 1, 1);
        vecs[10] = mk(0, 0, 0, 16'hFFFF, 0, 16'h00A0, 1, 1);
        vecs[11] = mk(0, 0, 0, 16'h0000, 0, 16'h00A0, 0, 0);
        vecs[12] = mk(0, 1, 1, 16'h0100, 1, 16'h0100, 1, 1);
        vecs[13] = mk(1, 1, 1, 16'h0200, 0, 16'h0100, 1, 1);
        vecs[14] = mk(1, 1, 1, 16'h0200, 0, 16'h0100, 1, 1);
        vecs[15] = mk(0, 1, 1, 16'h0200, 0, 16'h0100, 1, 1);
        vecs[16] = mk(0, 1, 1, 16'h0200, 0, 16'h0100, 0, 0);
        vecs[17] = mk(0, 1, 1, 16'h0300, 1, 16'h0300, 1, 1);
        vecs[18] = mk(0, 0, 0, 16'h0000, 0, 16'h0300, 1, 1);
        vecs[19] = mk(0, 0, 0, 16'h0000, 0, 16'h0300, 0, 0);
        vecs[20] = mk(1, 1, 0, 16'h0555, 0, 16'h0300, 0, 0);

        repeat (3) step();
        chk_outs("reset_hold", 1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_outs("post_reset_idle", 1'b0, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].st, vecs[i].br, vecs[i].tk, vecs[i].tgt);
            e.row = i; e.rd = vecs[i].rd; e.rpc = vecs[i].rpc; e.fl = vecs[i].fl; e.bz = vecs[i].bz;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            chk_outs($sformatf("row%0d", e.row), e.rd, e.rpc, e.fl, e.bz);
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        // Reset asserted in the middle of a FLUSH episode.
        drive(1'b0, 1'b1, 1'b1, 16'h0777);
        step();
        chk_outs("rst_flush_pre", 1'b1, 16'h0777, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("rst_flush_async", 1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk_outs("rst_flush_release", 1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 16'h0888);
        step();
        chk_outs("rst_flush_retrig", 1'b1, 16'h0888, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk_outs("rst_flush_retrig2", 1'b0, 16'h0888, 1'b1, 1'b1);
        step();
        chk_outs("rst_flush_retrig3", 1'b0, 16'h0888, 1'b0, 1'b0);

        // Reset asserted while a redirect is pending in HOLD.
        drive(1'b1, 1'b1, 1'b1, 16'h0999);
        step();
        chk_outs("rst_hold_pre", 1'b0, 16'h0999, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("rst_hold_async", 1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        rst_n = 1'b1;
        step();
        chk_outs("rst_hold_release", 1'b0, 16'h0000, 1'b0, 1'b0);

`ifdef BRANCH_PERF_CNT_EN
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("perf_clr_br", 32'(br_count), 32'd0);
        chk("perf_clr_taken", 32'(taken_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, (k < 3) ? 1'b1 : 1'b0, 16'(16'h0400 + k));
            step();
            drive(1'b0, 1'b0, 1'b0, 16'h0000);
            repeat (4) step();
        end
        chk("perf_br_count", 32'(br_count), 32'd5);
        chk("perf_taken_count", 32'(taken_count), 32'd3);
        drive(1'b0, 1'b1, 1'b1, 16'h0500);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("perf_clr_prio_br", 32'(br_count), 32'd0);
        chk("perf_clr_prio_taken", 32'(taken_count), 32'd0);
        chk_outs("perf_clr_trig", 1'b1, 16'h0500, 1'b1, 1'b1);
        repeat (3) step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the pipeline response to a resolved conditional branch in the EX stage.
- Consumes the taken/not-taken decision from the branch condition logic and the computed target.
- Issues a one-cycle PC redirect to fetch, then holds wrong-path flushes on IF/ID and ID/EX for a fixed number of advancing cycles.
- Sits between the EX-stage branch logic, the PC register and the pipeline-register flush controls, and tolerates downstream pipeline stalls.

Parameters:
- PC_W, 16, width of PC and branch target.
- FLUSH_CYCLES, 2, number of advancing (non-stalled) cycles flush_if/flush_id stay asserted after a redirect; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_branch  input  1  valid branch instruction present in EX this cycle.
- ex_taken  input  1  branch condition result from the branch logic; only meaningful when ex_branch=1.
- ex_target  input  PC_W  branch target computed in EX.
- pipe_stall  input  1  pipeline frozen this cycle; no pipeline register advances.
- pc_redirect  output  1  one-cycle pulse: load redirect_pc into the PC.
- redirect_pc  output  PC_W  target for PC load; valid when pc_redirect=1.
- flush_if  output  1  squash the IF/ID register contents.
- flush_id  output  1  squash the ID/EX register contents.
- busy  output  1  controller not in IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, async, any time including mid-flush or HOLD):
  - state=IDLE, flush counter=0, latched target=0.
  - pc_redirect, flush_if, flush_id, busy = 0; redirect_pc = 0.
- States:
  - IDLE: no branch activity outstanding.
  - HOLD: taken branch resolved during a stall; target latched, redirect pending.
  - FLUSH: wrong-path squash in progress.
- Trigger: rising edge at which ex_branch=1 and ex_taken=1 in IDLE.
- IDLE transitions:
  - Trigger with pipe_stall=0: latch ex_target and go to FLUSH. In the next cycle pc_redirect=1 (exactly one cycle), redirect_pc=latched target, flush_if=flush_id=1, counter loaded with FLUSH_CYCLES.
  - Trigger with pipe_stall=1: latch ex_target, go to HOLD, busy=1. No redirect or flush yet.
  - ex_branch=1 with ex_taken=0: no action; stay IDLE, all outputs 0.
- HOLD:
  - ex_branch and ex_taken are ignored.
  - The latched target is retained and never overwritten.
  - First edge with pipe_stall=0: behave as the IDLE no-stall trigger, using the latched target. Redirect appears the cycle after the stall drops.
- FLUSH:
  - flush_if and flush_id held at 1.
  - Counter decrements only on edges with pipe_stall=0.
  - Counter reaching 0: next cycle flush_if=flush_id=0, busy=0, state=IDLE.
  - ex_branch is ignored for the whole state; EX holds wrong-path instructions.
  - pc_redirect is never reasserted within one FLUSH episode.
- Latency:
  - Resolution to redirect: 1 cycle without a stall.
  - Total flush duration: FLUSH_CYCLES plus the number of stalled cycles inside FLUSH.
- Back-to-back: a taken branch sampled on the same edge that FLUSH exits to IDLE is not a trigger. IDLE evaluates triggers starting with the following edge.
- redirect_pc: holds the last latched target whenever pc_redirect=0; it is not cleared outside reset.
- busy=1 in HOLD and FLUSH, 0 in IDLE.
- Counter width: 3 bits. FLUSH_CYCLES=0 or >7 is illegal; the implementation raises a simulation-time error.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- Defined: adds output ports br_count[15:0] and taken_count[15:0], plus input perf_clr.
  - br_count increments on each edge with ex_branch=1 while state=IDLE and pipe_stall=0.
  - taken_count increments on each trigger accepted from IDLE, whether it goes to FLUSH or HOLD.
  - Both wrap from 16'hFFFF to 0.
  - Both reset to 0 on rst_n=0.
  - perf_clr=1 synchronously clears both and has priority over an increment on the same edge.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-FLUSH: assert rst_n=0 during FLUSH -> all outputs 0 immediately; after release, busy=0 and a new taken branch behaves normally.
- Taken, no stall: ex_branch=1, ex_taken=1, ex_target=16'h0040 at cycle N -> cycle N+1: pc_redirect=1, redirect_pc=16'h0040; flush_if=flush_id=1 for cycles N+1..N+2 (FLUSH_CYCLES=2); busy=0 at N+3.
- Not-taken: ex_branch=1, ex_taken=0, target 16'h1234 -> pc_redirect, flush_if, flush_id and busy stay 0 for all cycles; redirect_pc unchanged.
- Stall at resolution: taken branch, target 16'h00A0, with pipe_stall=1 for 3 cycles, and ex_target changing to 16'hFFFF during HOLD -> no redirect while stalled, busy=1. Redirect pulses the cycle after pipe_stall drops with redirect_pc=16'h00A0.
- Stall inside FLUSH: pipe_stall=1 for 2 cycles after redirect, with a second taken branch presented during FLUSH -> flush asserted for 4 cycles total; no second pc_redirect.
- BRANCH_PERF_CNT_EN defined: 5 branches, 3 taken, no stalls and spaced beyond the flush window -> br_count=5, taken_count=3. perf_clr=1 on the same edge as a taken branch -> both read 0 afterwards.
